// File: rtl/hddext_pkg.sv
// Shared constants, FSM state type and helpers for the IDE extension-port bridge.
package hddext_pkg;

    localparam int MAX_CHANNELS = 4;
    localparam int CNT_W        = 4;

    localparam logic [2:0] REG_ALT_STATUS = 3'd6;
    localparam logic [7:0] FLOAT_BYTE     = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } hddext_state_t;

    // A single channel still needs one select bit so port widths stay legal.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hddext_lat_cnt.sv
// Loadable down-counter that times the downstream read latency.
module hddext_lat_cnt
    import hddext_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign last  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hddext_mc.sv
// Bridges the CPU I/O Avalon window to the device-control/alt-status port of N IDE channels.
//   state   | meaning
//   IDLE    | accept writes (zero wait) or reads (strobe channel once)
//   RD_WAIT | read strobe issued, counting down the channel read latency
//   RD_DONE | io_readdata valid, read completes this cycle
module hddext_mc
    import hddext_pkg::*;
#(
    parameter  int         CHANNELS     = 2,
    parameter  int         READ_LATENCY = 1,
    parameter  logic [2:0] PORT_REG     = REG_ALT_STATUS,
    parameter  logic [7:0] FLOAT_VALUE  = FLOAT_BYTE,
    localparam int         CH_W         = ch_width(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH_W+2:0]       io_address,
    input  logic                  io_read,
    input  logic                  io_write,
    input  logic [7:0]            io_writedata,
    output logic [7:0]            io_readdata,
    output logic                  io_waitrequest,
    input  logic [CHANNELS-1:0]   ch_present,
    output logic [CHANNELS-1:0]   ch_read,
    output logic [CHANNELS-1:0]   ch_write,
    output logic [7:0]            ch_writedata,
    input  logic [8*CHANNELS-1:0] ch_readdata
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(READ_LATENCY);

    hddext_state_t state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [7:0]      rdata_q, rdata_d;

    logic [CH_W-1:0] ch;
    logic [2:0]      off;
    logic [CH_W-1:0] sel_ch;
    logic            sel_present;
    logic [7:0]      sel_data;
    logic            hit;
    logic            cnt_load;
    logic            cnt_last;
    logic [CNT_W-1:0] cnt_value;

    assign ch  = io_address[CH_W+2:3];
    assign off = io_address[2:0];

    // The mux follows the live address in IDLE and the latched channel while waiting.
    assign sel_ch = (state_q == IDLE) ? ch : ch_q;

    always_comb begin
        sel_present = 1'b0;
        sel_data    = FLOAT_VALUE;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel_ch == CH_W'(c)) begin
                sel_present = ch_present[c];
                sel_data    = ch_readdata[8*c +: 8];
            end
        end
    end

    assign hit = (off == PORT_REG) && sel_present;

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        rdata_d        = rdata_q;
        cnt_load       = 1'b0;
        ch_read        = '0;
        ch_write       = '0;
        io_waitrequest = 1'b0;
        case (state_q)
            IDLE: begin
                if (io_write) begin
                    if (hit) begin
                        ch_write = CHANNELS'(1) << ch;
                    end
                end else if (io_read) begin
                    io_waitrequest = 1'b1;
                    if (hit) begin
                        ch_read  = CHANNELS'(1) << ch;
                        ch_d     = ch;
                        cnt_load = 1'b1;
                        if (LAT == '0) begin
                            rdata_d = sel_data;
                            state_d = RD_DONE;
                        end else begin
                            state_d = RD_WAIT;
                        end
                    end else begin
                        rdata_d = FLOAT_VALUE;
                        state_d = RD_DONE;
                    end
                end
            end
            RD_WAIT: begin
                io_waitrequest = 1'b1;
                if (cnt_last) begin
                    rdata_d = sel_data;
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                io_waitrequest = io_write;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rdata_q <= rdata_d;
        end
    end

    hddext_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .en         (state_q == RD_WAIT),
        .load_value (LAT),
        .value      (cnt_value),
        .last       (cnt_last)
    );

    assign io_readdata  = rdata_q;
    assign ch_writedata = io_writedata;

endmodule

// File: tb/tb_hddext_mc.sv
// Directed plus randomized transaction checks of hddext_mc at read latencies 0, 1 and 3.
module tb_hddext_mc;

    localparam int N = 3;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]  io_address     [N];
    logic        io_read        [N];
    logic        io_write       [N];
    logic [7:0]  io_writedata   [N];
    logic [7:0]  io_readdata    [N];
    logic        io_waitrequest [N];
    logic [1:0]  ch_present     [N];
    logic [1:0]  ch_read        [N];
    logic [1:0]  ch_write       [N];
    logic [7:0]  ch_writedata   [N];
    logic [15:0] ch_readdata    [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        hddext_mc #(
            .CHANNELS     (2),
            .READ_LATENCY (lat_of(g))
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .io_address     (io_address[g]),
            .io_read        (io_read[g]),
            .io_write       (io_write[g]),
            .io_writedata   (io_writedata[g]),
            .io_readdata    (io_readdata[g]),
            .io_waitrequest (io_waitrequest[g]),
            .ch_present     (ch_present[g]),
            .ch_read        (ch_read[g]),
            .ch_write       (ch_write[g]),
            .ch_writedata   (ch_writedata[g]),
            .ch_readdata    (ch_readdata[g])
        );
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] last_rd [N];

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed 0x%0h expected 0x%0h", tag, i, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag, input int i);
        chk({tag, "_ch_read"}, i, 32'(ch_read[i]), 0);
        chk({tag, "_ch_write"}, i, 32'(ch_write[i]), 0);
        chk({tag, "_wait"}, i, 32'(io_waitrequest[i]), 0);
        chk({tag, "_rdata"}, i, 32'(io_readdata[i]), 32'(last_rd[i]));
    endtask

    // Read transaction: channel data is only valid in the cycle the bridge should sample it.
    task automatic do_read(input int i, input int ch, input int off, input logic [7:0] val);
        int         lat       = lat_of(i);
        bit         hit       = (off == 6) && ch_present[i][ch];
        int         exp_stall = hit ? lat + 1 : 1;
        logic [7:0] exp       = hit ? val : 8'hFF;
        int         strobes   = 0;
        int         stall     = 0;
        bit         done      = 0;
        logic [15:0] rd;
        @(posedge clk); #1;
        io_address[i] = {ch[0], off[2:0]};
        io_read[i]    = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            rd = 16'($urandom);
            rd[8*ch +: 8] = (k == lat) ? val : ~val;
            ch_readdata[i] = rd;
            @(negedge clk);
            if (ch_read[i] != 2'b00) begin
                strobes++;
                chk("rd_strobe_sel", i, 32'(ch_read[i]), 32'(1) << ch);
            end
            chk("rd_no_write", i, 32'(ch_write[i]), 0);
            if (!io_waitrequest[i]) begin
                done = 1;
                chk("rd_data", i, 32'(io_readdata[i]), 32'(exp));
            end else begin
                stall++;
                @(posedge clk); #1;
            end
        end
        chk("rd_completed", i, 32'(done), 1);
        chk("rd_stall", i, 32'(stall), 32'(exp_stall));
        chk("rd_strobes", i, 32'(strobes), hit ? 1 : 0);
        last_rd[i] = exp;
        @(posedge clk); #1;
        io_read[i]     = 1'b0;
        ch_readdata[i] = 16'($urandom);
        @(negedge clk);
        check_quiet("rd_after", i);
    endtask

    task automatic do_write(input int i, input int ch, input int off, input logic [7:0] val, input bit with_read);
        bit hit = (off == 6) && ch_present[i][ch];
        @(posedge clk); #1;
        io_address[i]   = {ch[0], off[2:0]};
        io_writedata[i] = val;
        io_write[i]     = 1'b1;
        io_read[i]      = with_read;
        @(negedge clk);
        chk("wr_strobe", i, 32'(ch_write[i]), hit ? (32'(1) << ch) : 0);
        chk("wr_wdata", i, 32'(ch_writedata[i]), 32'(val));
        chk("wr_wait", i, 32'(io_waitrequest[i]), 0);
        chk("wr_no_read", i, 32'(ch_read[i]), 0);
        @(posedge clk); #1;
        io_write[i] = 1'b0;
        io_read[i]  = 1'b0;
        @(negedge clk);
        check_quiet("wr_after", i);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            io_address[i]   = '0;
            io_read[i]      = 1'b0;
            io_write[i]     = 1'b0;
            io_writedata[i] = '0;
            ch_present[i]   = 2'b11;
            ch_readdata[i]  = 16'hBEEF;
            last_rd[i]      = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) check_quiet("reset", i);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases
        do_read(1, 1, 6, 8'h5A);
        do_read(0, 0, 6, 8'hC3);
        do_write(0, 0, 6, 8'h04, 0);
        do_write(0, 1, 5, 8'h04, 0);
        ch_present[1] = 2'b01;
        do_read(1, 1, 6, 8'h77);
        ch_present[1] = 2'b11;
        do_write(1, 0, 6, 8'h3C, 1);
        do_read(2, 1, 6, 8'hA7);

        // Reset while instance 2 sits in RD_WAIT
        @(posedge clk); #1;
        io_address[2]  = 4'b0110;
        io_read[2]     = 1'b1;
        ch_readdata[2] = 16'h1234;
        @(negedge clk);
        chk("mid_strobe", 2, 32'(ch_read[2]), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b0;
        io_read[2] = 1'b0;
        for (int i = 0; i < N; i++) last_rd[i] = 8'h00;
        @(negedge clk);
        for (int i = 0; i < N; i++) check_quiet("mid_reset", i);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_quiet("post_reset", 2);
        end
        do_read(2, 0, 6, 8'h96);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            int i   = $urandom_range(0, N - 1);
            int op  = $urandom_range(0, 2);
            int ch  = $urandom_range(0, 1);
            int off = ($urandom_range(0, 1) == 1) ? 6 : $urandom_range(0, 7);
            ch_present[i] = 2'($urandom);
            if (op == 0) begin
                do_read(i, ch, off, 8'($urandom));
            end else begin
                do_write(i, ch, off, 8'($urandom), op == 2);
            end
            ch_present[i] = 2'b11;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
